ecb_enc_serial: RTL and testbench

Bit-serial ECB encryption engine, the transmit-side counterpart of the per-bit XOR decryptor. It captures a W-bit plaintext block and XORs it with a stored W-bit key. The resulting ciphertext is shifted out one bit per accepted cycle, so that each serial bit can be fed straight into a 1-bit decryptor paired with the matching key bit. It sits between the plaintext source and the serial link, with valid/ready handshakes on both sides.

---
 rtl/ecb_enc_serial.sv | 128 ++++++++++++
 tb/tb_ecb_enc_serial.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecb_enc_serial.sv
// ecb_enc_serial
//   Bit-serial ECB encryption engine. A W-bit plaintext block is XORed with a
//   stored W-bit key and the ciphertext is shifted out LSB first, one bit per
//   accepted downstream handshake.
//
//   Optional feature macro: ECB_ENC_PARITY_EN
//     defined   -> an extra even-parity bit (XOR of all ciphertext bits) follows
//                  the W ciphertext bits and carries ct_last.
//     undefined -> W bits per block, ct_last on ciphertext bit W-1.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   K         in   key value
//   key_load  in   capture K into the key register (IDLE only)
//   PT        in   plaintext block
//   pt_valid  in   plaintext valid
//   pt_ready  out  engine can accept a block (state == IDLE)
//   ct_bit    out  current ciphertext bit, LSB first
//   ct_valid  out  ct_bit is valid
//   ct_last   out  current bit is the final bit of the block
//   ct_ready  in   downstream accepts ct_bit this cycle
//   busy      out  state == SHIFT
//
// States
//   IDLE  | waiting for a plaintext block; key may be loaded
//   SHIFT | presenting ciphertext bits to the serial link
`timescale 1ns/1ps

module ecb_enc_serial #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] K,
    input  logic         key_load,
    input  logic [W-1:0] PT,
    input  logic         pt_valid,
    output logic         pt_ready,
    output logic         ct_bit,
    output logic         ct_valid,
    output logic         ct_last,
    input  logic         ct_ready,
    output logic         busy
);

`ifdef ECB_ENC_PARITY_EN
    localparam int NBITS = W + 1;
`else
    localparam int NBITS = W;
`endif
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NBITS-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     key_reg;
    logic [W-1:0]     keff;
    logic [W-1:0]     ct_word;
    logic             load;
    logic             advance;
    logic             done;

    // A key presented together with the block is used for that block.
    assign keff    = key_load ? K : key_reg;
    assign ct_word = PT ^ keff;

    assign load    = (state == IDLE) && pt_valid;
    assign advance = (state == SHIFT) && ct_ready;
    assign done    = advance && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pt_valid) state_nxt = SHIFT;
            SHIFT:   if (done)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
            shreg   <= '0;
            cnt     <= '0;
        end else begin
            if ((state == IDLE) && key_load) begin
                key_reg <= K;
            end
            if (load) begin
`ifdef ECB_ENC_PARITY_EN
                // Parity is latched into the top of the shifter so it simply
                // falls out after the W ciphertext bits.
                shreg <= {^ct_word, ct_word};
`else
                shreg <= ct_word;
`endif
                cnt   <= '0;
            end else if (advance) begin
                shreg <= {1'b0, shreg[NBITS-1:1]};
                cnt   <= cnt + 1'b1;
            end
        end
    end

    // All serial outputs decode from registers only; ct_ready never reaches them.
    assign pt_ready = (state == IDLE);
    assign busy     = (state == SHIFT);
    assign ct_valid = busy;
    assign ct_bit   = busy & shreg[0];
    assign ct_last  = busy && (cnt == CNT_LAST);

endmodule

// File: tb/tb_ecb_enc_serial.sv
`timescale 1ns/1ps

module tb_ecb_enc_serial;

    localparam int W = 8;
`ifdef ECB_ENC_PARITY_EN
    localparam int NB  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] K;
    logic         key_load;
    logic [W-1:0] PT;
    logic         pt_valid;
    logic         pt_ready;
    logic         ct_bit;
    logic         ct_valid;
    logic         ct_last;
    logic         ct_ready;
    logic         busy;

    ecb_enc_serial #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .K        (K),
        .key_load (key_load),
        .PT       (PT),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .ct_bit   (ct_bit),
        .ct_valid (ct_valid),
        .ct_last  (ct_last),
        .ct_ready (ct_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic exp;
        logic xk;
        logic last;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hs_count = 0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Expected serial stream: bit i must satisfy ct_bit ^ xkey[i] == word[i].
    task automatic push_block(input logic [W-1:0] word, input logic [W-1:0] xkey);
        for (int i = 0; i < W; i++) begin
            sbq.push_back('{exp: word[i], xk: xkey[i], last: (!PAR && i == W-1)});
        end
        if (PAR) sbq.push_back('{exp: ^(word ^ xkey), xk: 1'b0, last: 1'b1});
    endtask

    // Monitor: pops one expectation per serial handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ct_valid === 1'b1 && ct_ready === 1'b1) begin
                hs_count++;
                if (sbq.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("ct_bit", ct_bit ^ e.xk, e.exp);
                    check("ct_last", ct_last, e.last);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) ct_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_ready();
        int t = 0;
        while (!pt_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("pt_ready_wait", pt_ready, 1);
    endtask

    task automatic send(input logic [W-1:0] pt, input bit kl, input logic [W-1:0] k,
                        input logic [W-1:0] word, input logic [W-1:0] xkey);
        wait_ready();
        push_block(word, xkey);
        PT       = pt;
        K        = k;
        key_load = kl;
        pt_valid = 1'b1;
        @(posedge clk);
        #1;
        pt_valid = 1'b0;
        key_load = 1'b0;
        check("ct_valid_latency", ct_valid, 1);
        check("pt_ready_busy", pt_ready, 0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", sbq.size(), 0);
        @(posedge clk);
        #1;
        check("pt_ready_after", pt_ready, 1);
        check("ct_valid_after", ct_valid, 0);
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        while (hs_count < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("hs_reached", hs_count, n);
    endtask

    initial begin
        logic [W-1:0] kmodel;
        logic [W-1:0] pt;
        logic [W-1:0] k;
        bit           kl;

        rst_n    = 1'b0;
        K        = '0;
        key_load = 1'b0;
        PT       = '0;
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        #1;
        check("rst_ct_valid", ct_valid, 0);
        check("rst_ct_bit", ct_bit, 0);
        check("rst_ct_last", ct_last, 0);
        check("rst_busy", busy, 0);
        check("rst_pt_ready", pt_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic encrypt: key A5, PT 3C -> 99
        @(posedge clk);
        #1;
        key_load = 1'b1;
        K        = 8'hA5;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        check("idle_after_keyload", pt_ready, 1);
        hs_count = 0;
        send(8'h3C, 1'b0, 8'h00, 8'h99, 8'h00);
        wait_done();
        check("basic_hs_total", hs_count, NB);

        // Backpressure after bit 2
        hs_count = 0;
        send(8'h3C, 1'b0, 8'h00, 8'h99, 8'h00);
        wait_hs(2);
        @(posedge clk);
        #1;
        ct_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_bit", ct_bit, 0);
            check("bp_valid", ct_valid, 1);
            check("bp_last", ct_last, 0);
            check("bp_cnt", dut.cnt, 2);
        end
        @(posedge clk);
        #1;
        ct_ready = 1'b1;
        wait_done();
        check("bp_hs_total", hs_count, NB);

        // key_load during SHIFT is ignored
        send(8'h3C, 1'b0, 8'h00, 8'h99, 8'h00);
        @(posedge clk);
        #1;
        key_load = 1'b1;
        K        = 8'hFF;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        wait_done();
        send(8'h00, 1'b0, 8'hFF, 8'hA5, 8'h00);
        wait_done();

        // Simultaneous key_load and PT
        send(8'hF0, 1'b1, 8'h0F, 8'hFF, 8'h00);
        wait_done();
        send(8'h00, 1'b0, 8'h00, 8'h0F, 8'h00);
        wait_done();

        // Reset after bit 4 (key is 0F here: 3C ^ 0F = 33)
        hs_count = 0;
        send(8'h3C, 1'b0, 8'h00, 8'h33, 8'h00);
        wait_hs(4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("mid_rst_ct_valid", ct_valid, 0);
        check("mid_rst_ct_bit", ct_bit, 0);
        check("mid_rst_ct_last", ct_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pt_ready", pt_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h12, 1'b0, 8'h00, 8'h12, 8'h00);
        wait_done();

        // Round trip through per-bit decryption with random backpressure
        kmodel   = '0;
        rand_rdy = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            pt = W'($urandom);
            k  = W'($urandom);
            kl = 1'($urandom_range(0, 1));
            if (kl) kmodel = k;
            send(pt, kl, k, pt, kmodel);
            wait_done();
        end
        rand_rdy = 1'b0;
        ct_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
